// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared definitions for the data-memory controller: RISC-V
//               funct3 access codes, controller FSM states, byte-enable type.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  // Load/store width and extension codes (funct3 field)
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Request/response controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // One enable bit per byte lane of a 32-bit word
  typedef logic [3:0] byte_en_t;

endpackage
`default_nettype wire

// File: rtl/load_store_align.sv
`default_nettype none
// ============================================================================
// Module      : load_store_align
// Description : Combinational lane logic. Builds byte enables and replicates
//               store data across lanes; selects and extends load data.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output byte_en_t    be_o,
  output logic [31:0] wlanes_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = rword_i[{offset_i, 3'b000} +: 8];
  assign w_half = offset_i[1] ? rword_i[31:16] : rword_i[15:0];

  // Store path: replicate data into every lane, enables pick which lanes land
  always_comb begin
    be_o     = '0;
    wlanes_o = '0;
    case (funct3_i)
      F3_B: begin
        be_o     = byte_en_t'(4'b0001 << offset_i);
        wlanes_o = {4{wdata_i[7:0]}};
      end
      F3_H: begin
        be_o     = offset_i[1] ? 4'b1100 : 4'b0011;
        wlanes_o = {2{wdata_i[15:0]}};
      end
      F3_W: begin
        be_o     = 4'b1111;
        wlanes_o = wdata_i;
      end
      default: begin
        be_o     = '0;
        wlanes_o = '0;
      end
    endcase
  end

  // Load path: pick the addressed byte/halfword and sign- or zero-extend it
  always_comb begin
    rdata_o = '0;
    case (funct3_i)
      F3_B:    rdata_o = {{24{w_byte[7]}}, w_byte};
      F3_BU:   rdata_o = {24'd0, w_byte};
      F3_H:    rdata_o = {{16{w_half[15]}}, w_half};
      F3_HU:   rdata_o = {16'd0, w_half};
      F3_W:    rdata_o = rword_i;
      default: rdata_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_ctrl
// Description : Word-organised data memory with request/response handshake,
//               programmable response latency, byte/half/word access and
//               misaligned / out-of-range / illegal-funct3 error reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [2:0]      req_funct3_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_err_o
);

  localparam int IDXW = $clog2(DEPTH);
  // BUSY counts down from LATENCY-2 so that RESP is reached LATENCY edges after acceptance
  localparam logic [1:0] CNT_INIT = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

  state_e          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [XLEN-1:0] mem_q [DEPTH];

  logic            w_accept;
  logic [IDXW-1:0] w_idx;
  logic [1:0]      w_off;
  logic            w_misaligned;
  logic            w_out_of_range;
  logic            w_illegal;
  logic            w_err;
  logic            w_wr_en;
  byte_en_t        w_be;
  logic [XLEN-1:0] w_wlanes;
  logic [XLEN-1:0] w_ld_data;

  assign w_accept = req_valid_i && (state_q == ST_IDLE);
  assign w_idx    = req_addr_i[2 +: IDXW];
  assign w_off    = req_addr_i[1:0];

  // funct3[1:0] encodes access size: 01 = halfword, 10 = word
  assign w_misaligned   = ((req_funct3_i[1:0] == 2'b01) && w_off[0]) ||
                          ((req_funct3_i[1:0] == 2'b10) && (w_off != 2'b00));
  // DEPTH is a power of two, so any set bit above the index is out of range
  assign w_out_of_range = |req_addr_i[XLEN-1:2+IDXW];
  assign w_illegal      = req_we_i ? (req_funct3_i > F3_W)
                                   : ((req_funct3_i == 3'd3) || (req_funct3_i[2:1] == 2'b11));
  assign w_err          = w_misaligned || w_out_of_range || w_illegal;
  assign w_wr_en        = w_accept && req_we_i && !w_err;

  load_store_align u_align (
    .funct3_i (req_funct3_i),
    .offset_i (w_off),
    .wdata_i  (req_wdata_i),
    .rword_i  (mem_q[w_idx]),
    .be_o     (w_be),
    .wlanes_o (w_wlanes),
    .rdata_o  (w_ld_data)
  );

  // Next-state: accept in IDLE, count down in BUSY, wait for consumer in RESP
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          rdata_d = (req_we_i || w_err) ? '0 : w_ld_data;
          err_d   = w_err;
          if (LATENCY == 1) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_BUSY: begin
        if (cnt_q == 2'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 2'd1;
      end
      ST_RESP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and response registers; reset drops any pending response
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage: byte-lane writes committed on the acceptance edge, never reset
  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) mem_q[w_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
      end
    end
  end

  assign req_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_ctrl
// Description : Self-checking bench for data_mem_ctrl. Three instances with
//               LATENCY 1, 3 and 4 run against a byte-addressed memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]       req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [2:0][31:0] req_addr, req_wdata, rsp_rdata;
  logic [2:0][2:0]  req_f3;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference memory, one byte per address, per instance
  logic [7:0] mem_m [3][4096];

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      data_mem_ctrl #(
        .XLEN    (32),
        .DEPTH   (1024),
        .LATENCY ((g == 0) ? 1 : ((g == 1) ? 3 : 4))
      ) u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid[g]),
        .req_ready_o  (req_ready[g]),
        .req_we_i     (req_we[g]),
        .req_addr_i   (req_addr[g]),
        .req_funct3_i (req_f3[g]),
        .req_wdata_i  (req_wdata[g]),
        .rsp_valid_o  (rsp_valid[g]),
        .rsp_ready_i  (rsp_ready[g]),
        .rsp_rdata_o  (rsp_rdata[g]),
        .rsp_err_o    (rsp_err[g])
      );
    end
  endgenerate

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Architectural model: byte-addressed, little-endian, errors from the ISA rules
  task automatic model(input int i, input bit we, input logic [31:0] addr,
                       input logic [2:0] f3, input logic [31:0] wd,
                       output logic [31:0] er, output logic ee);
    int          nb;
    bit          legal;
    logic [31:0] v;
    nb    = 1 << f3[1:0];
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    ee    = !legal || ((addr % nb) != 0) || (addr >= 32'd4096);
    er    = '0;
    if (!ee) begin
      if (we) begin
        for (int k = 0; k < nb; k++) mem_m[i][addr + k] = wd[8*k +: 8];
      end else begin
        v = '0;
        for (int k = 0; k < nb; k++) v[8*k +: 8] = mem_m[i][addr + k];
        if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
        er = v;
      end
    end
  endtask

  // Present one request and return just after its acceptance edge; then drive
  // a junk store that must be ignored while the block is not ready
  task automatic issue(input int i, input bit we, input logic [31:0] addr,
                       input logic [2:0] f3, input logic [31:0] wd);
    @(negedge clk);
    chk("req_ready_idle", {31'd0, req_ready[i]}, 32'd1);
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_addr[i]  = addr;
    req_f3[i]    = f3;
    req_wdata[i] = wd;
    @(posedge clk);
    #1;
    req_we[i]    = 1'b1;
    req_f3[i]    = 3'd2;
    req_addr[i]  = 32'($urandom_range(0, 15)) << 2;
    req_wdata[i] = $urandom;
  endtask

  task automatic do_txn(input int i, input bit we, input logic [31:0] addr,
                        input logic [2:0] f3, input logic [31:0] wd, input int hold,
                        output logic [31:0] got, output logic gerr);
    logic [31:0] er;
    logic        ee;
    int          cnt;
    model(i, we, addr, f3, wd, er, ee);
    rsp_ready[i] = 1'b0;
    issue(i, we, addr, f3, wd);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (!rsp_valid[i]) chk("req_ready_busy", {31'd0, req_ready[i]}, 32'd0);
    end while (!rsp_valid[i] && cnt < 20);
    chk("latency", cnt, lat_of(i));
    chk("rsp_valid", {31'd0, rsp_valid[i]}, 32'd1);
    chk("rdata", rsp_rdata[i], er);
    chk("err", {31'd0, rsp_err[i]}, {31'd0, ee});
    chk("req_ready_resp", {31'd0, req_ready[i]}, 32'd0);
    got  = rsp_rdata[i];
    gerr = rsp_err[i];
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, rsp_valid[i]}, 32'd1);
      chk("hold_rdata", rsp_rdata[i], er);
      chk("hold_err", {31'd0, rsp_err[i]}, {31'd0, ee});
      chk("hold_ready", {31'd0, req_ready[i]}, 32'd0);
    end
    req_valid[i] = 1'b0;
    rsp_ready[i] = 1'b1;
    @(posedge clk);
    #1 rsp_ready[i] = 1'b0;
    @(negedge clk);
    chk("valid_drop", {31'd0, rsp_valid[i]}, 32'd0);
    chk("ready_back", {31'd0, req_ready[i]}, 32'd1);
  endtask

  task automatic chk_reset_outputs(input int i);
    chk("rst_req_ready", {31'd0, req_ready[i]}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid[i]}, 32'd0);
    chk("rst_rdata", rsp_rdata[i], 32'd0);
    chk("rst_err", {31'd0, rsp_err[i]}, 32'd0);
  endtask

  initial begin
    logic [31:0] got, prev, er, addr;
    logic        gerr, ee;
    int          i, sel;
    logic [2:0]  f3;
    bit          we;

    rst       = 1'b1;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_f3    = '0;
    req_wdata = '0;
    rsp_ready = '0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) chk_reset_outputs(k);
    rst = 1'b0;

    // Give every instance known contents in words 0..15
    for (int k = 0; k < 3; k++)
      for (int w = 0; w < 16; w++)
        do_txn(k, 1'b1, 32'(w * 4), 3'd2, $urandom, 0, got, gerr);

    // Word store/load, then byte store and extended loads (LATENCY 1)
    do_txn(0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 0, got, gerr);
    chk("sw_rdata_zero", got, 32'd0);
    do_txn(0, 1'b0, 32'h10, 3'd2, 32'd0, 0, got, gerr);
    chk("lw_10", got, 32'hDEADBEEF);
    do_txn(0, 1'b1, 32'h11, 3'd0, 32'h0000007F, 0, got, gerr);
    do_txn(0, 1'b0, 32'h10, 3'd2, 32'd0, 0, got, gerr);
    chk("lw_10_after_sb", got, 32'hDEAD7FEF);
    do_txn(0, 1'b0, 32'h11, 3'd0, 32'd0, 0, got, gerr);
    chk("lb_11", got, 32'h0000007F);
    do_txn(0, 1'b0, 32'h13, 3'd4, 32'd0, 0, got, gerr);
    chk("lbu_13", got, 32'h000000DE);
    do_txn(0, 1'b0, 32'h12, 3'd1, 32'd0, 0, got, gerr);
    chk("lh_12", got, 32'hFFFFDEAD);

    // Error cases leave memory untouched
    do_txn(0, 1'b0, 32'h0C, 3'd2, 32'd0, 0, prev, gerr);
    do_txn(0, 1'b0, 32'h03, 3'd1, 32'd0, 0, got, gerr);
    chk("lh_03_err", {31'd0, gerr}, 32'd1);
    chk("lh_03_rdata", got, 32'd0);
    do_txn(0, 1'b1, 32'h0E, 3'd2, 32'hA5A5A5A5, 0, got, gerr);
    chk("sw_0e_err", {31'd0, gerr}, 32'd1);
    do_txn(0, 1'b0, 32'h1000, 3'd2, 32'd0, 0, got, gerr);
    chk("lw_1000_err", {31'd0, gerr}, 32'd1);
    do_txn(0, 1'b1, 32'h0C, 3'd3, 32'hFFFFFFFF, 0, got, gerr);
    chk("st_f3_3_err", {31'd0, gerr}, 32'd1);
    do_txn(0, 1'b0, 32'h0C, 3'd2, 32'd0, 0, got, gerr);
    chk("lw_0c_unchanged", got, prev);

    // LATENCY 3 with a consumer that stalls for 5 cycles
    do_txn(1, 1'b0, 32'h10, 3'd2, 32'd0, 5, got, gerr);

    // LATENCY 4: reset while BUSY keeps the committed store
    model(2, 1'b1, 32'h20, 3'd2, 32'h12345678, er, ee);
    rsp_ready[2] = 1'b0;
    issue(2, 1'b1, 32'h20, 3'd2, 32'h12345678);
    @(posedge clk);
    #2;
    rst          = 1'b1;
    req_valid[2] = 1'b0;
    #1;
    chk_reset_outputs(2);
    @(negedge clk);
    rst = 1'b0;
    do_txn(2, 1'b0, 32'h20, 3'd2, 32'd0, 0, got, gerr);
    chk("lw_20_after_rst", got, 32'h12345678);

    // LATENCY 3: reset while RESP drops the pending response
    rsp_ready[1] = 1'b0;
    issue(1, 1'b0, 32'h10, 3'd2, 32'd0);
    repeat (3) @(negedge clk);
    chk("resp_before_rst", {31'd0, rsp_valid[1]}, 32'd1);
    #2;
    rst          = 1'b1;
    req_valid[1] = 1'b0;
    #1;
    chk_reset_outputs(1);
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic across all instances
    for (int r = 0; r < 150; r++) begin
      i   = $urandom_range(0, 2);
      we  = 1'($urandom_range(0, 1));
      f3  = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 9);
      if (sel == 0) addr = $urandom | 32'h0000_1000;
      else          addr = 32'($urandom_range(0, 63));
      if (sel >= 1 && sel < 6) addr = addr & ~((32'd1 << f3[1:0]) - 32'd1);
      do_txn(i, we, addr, f3, $urandom, $urandom_range(0, 2), got, gerr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
